// File: rtl/md_unit.sv
// Multiply/divide unit: HI/LO registers with a fixed-latency IDLE/RUN sequencer.
// The result is computed at the accepting edge, then held until the latency has elapsed.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [4:0]  dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_e      state;
  logic [3:0]  count;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  logic        div_zero;
  logic        div_ovf;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [31:0] div_a;
  logic signed [31:0] div_b;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] divu_b;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_wr;
  logic        start;
  logic [3:0]  load;

  assign busy      = (state == RUN);
  assign dbg_state = {state, count};

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // The divisor is forced to 1 for the zero and overflow cases so the
  // arithmetic never sees an undefined input; those cases are patched below.
  assign div_zero = (src_b == 32'd0);
  assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign div_a    = $signed(src_a);
  assign div_b    = (div_zero || div_ovf) ? 32'sd1 : $signed(src_b);
  assign quo_s    = div_a / div_b;
  assign rem_s    = div_a % div_b;
  assign divu_b   = div_zero ? 32'd1 : src_b;
  assign quo_u    = src_a / divu_b;
  assign rem_u    = src_a % divu_b;

  always_comb begin
    calc_hi = 32'd0;
    calc_lo = 32'd0;
    calc_wr = 1'b0;
    start   = 1'b0;
    load    = 4'd0;
    case (md_op)
      OP_MULT: begin
        {calc_hi, calc_lo} = prod_s;
        calc_wr = 1'b1;
        start   = 1'b1;
        load    = MULT_LOAD;
      end
      OP_MULTU: begin
        {calc_hi, calc_lo} = prod_u;
        calc_wr = 1'b1;
        start   = 1'b1;
        load    = MULT_LOAD;
      end
      OP_DIV: begin
        start = 1'b1;
        load  = DIV_LOAD;
        if (div_ovf) begin
          calc_hi = 32'd0;
          calc_lo = 32'h8000_0000;
          calc_wr = 1'b1;
        end else if (!div_zero) begin
          calc_hi = rem_s;
          calc_lo = quo_s;
          calc_wr = 1'b1;
        end
      end
      OP_DIVU: begin
        start = 1'b1;
        load  = DIV_LOAD;
        if (!div_zero) begin
          calc_hi = rem_u;
          calc_lo = quo_u;
          calc_wr = 1'b1;
        end
      end
      default: begin
        calc_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            res_hi <= calc_hi;
            res_lo <= calc_lo;
            res_wr <= calc_wr;
            count  <= load;
            state  <= RUN;
          end else if (md_op == OP_MTHI) begin
            hi <= src_a;
          end else if (md_op == OP_MTLO) begin
            lo <= src_a;
          end
        end
        RUN: begin
          // Requests arriving here are dropped; the pipeline stalls on busy.
          count <= count - 4'd1;
          if (count <= 4'd1) begin
            state <= IDLE;
            done  <= 1'b1;
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected {hi,lo} pairs,
// directed corner cases followed by a short random sweep.
module tb_md_unit;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {m_hi, m_lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {m_hi, m_lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Called at a negedge; the following posedge samples the request.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    src_a = a;
    src_b = b;
    if (op >= OP_MULT && op <= OP_DIVU) exp_q.push_back(model(op, a, b));
    else if (op == OP_MTHI) m_hi = a;
    else if (op == OP_MTLO) m_lo = a;
    @(negedge clk);
    md_op = OP_NOP;
  endtask

  // Counts busy samples from the current one; returns at the sample where busy fell.
  task automatic wait_done(input string tag, input int start_cnt, input int exp_cycles);
    int cnt;
    int guard;
    logic [63:0] exp;
    cnt = start_cnt;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      cnt++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check({tag, "_hi"}, 64'(hi), 64'(m_hi));
      check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    issue(op, a, b);
    wait_done(tag, 0, (op == OP_MULT || op == OP_MULTU) ? 5 : 10);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    logic [2:0] op;
    logic [31:0] a, b;

    // Request held throughout reset must be ignored until release.
    md_op = OP_MULT;
    src_a = 32'hFFFF_FFFE;
    src_b = 32'h0000_0003;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("mult_neg", 0, 5);
    check("mult_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFFA);
    @(negedge clk);
    check("mult_neg_done_low", 64'(done), 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo_const", 64'(lo), 64'h0000_0001);

    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);

    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(OP_MTLO, 32'h5678, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h5678);
    check("mtlo_done", 64'(done), 64'd0);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0);
    check("divu_zero_hi_const", 64'(hi), 64'h1234);
    check("divu_zero_lo_const", 64'(lo), 64'h5678);

    // MTLO during RUN is dropped, src_a wobbles after capture, then a gapless DIVU.
    issue(OP_MULT, 32'd1000, 32'hFFFF_FFFD);
    @(negedge clk);
    md_op = OP_MTLO;
    src_a = 32'hAAAA;
    @(negedge clk);
    md_op = OP_NOP;
    src_a = $urandom;
    wait_done("mult_mid", 2, 5);
    check("mult_mid_lo_const", 64'(lo), 64'hFFFF_F448);
    issue(OP_DIVU, 32'd100, 32'd7);
    check("divu_gapless_busy", 64'(busy), 64'd1);
    wait_done("divu_gapless", 0, 10);
    check("divu_gapless_lo_const", 64'(lo), 64'd14);
    @(negedge clk);

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("arst_no_done", 64'(done_cnt), 64'd0);
    check("arst_hi_after", 64'(hi), 64'd0);

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi_const", 64'(hi), 64'd0);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_dead_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi_dead_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(0, 3) == 0) b = 32'd0;
      if (op >= OP_MULT && op <= OP_DIVU) begin
        run_op("rand_op", op, a, b);
      end else begin
        issue(op, a, b);
        check("rand_reg_hi", 64'(hi), 64'(m_hi));
        check("rand_reg_lo", 64'(lo), 64'(m_lo));
        check("rand_reg_busy", 64'(busy), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy-cycle count for MULT/MULTU (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10: busy-cycle count for DIV/DIVU (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 md_op  input  3  request from Execute: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
REQ-006 src_a  input  32  forwarded rs value (dividend / multiplicand / MTHI-MTLO data).
REQ-007 src_b  input  32  forwarded rt value (divisor / multiplier).
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse in the cycle immediately after hi/lo take a computed result.
REQ-010 hi  output  32  HI register contents (registered, drives MFHI path).
REQ-011 lo  output  32  LO register contents (registered, drives MFLO path).

Function
REQ-012 States SHALL be IDLE and RUN; a 4-bit down-counter SHALL track the remaining RUN cycles.
REQ-013 In IDLE, at a rising edge with md_op in 001..100, the unit SHALL compute the result from src_a/src_b, hold it in internal result registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 busy SHALL equal 1 exactly when state is RUN, so for N consecutive cycles after the accepting edge (N = the op's cycle count).
REQ-015 At the edge where the counter reaches zero, hi/lo SHALL load the held result, state SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-016 hi/lo SHALL remain unchanged throughout RUN until the completing edge.
REQ-017 Any md_op presented while busy=1 SHALL be ignored; the upstream stall logic is responsible for holding the requesting instruction.
REQ-018 A new operation SHALL be accepted at the first edge after busy falls, with no dead cycle required.
REQ-019 MTHI/MTLO in IDLE SHALL write src_a into hi or lo at that edge, with 0 latency; they SHALL NOT assert busy or done.
REQ-020 md_op 000 or 111 SHALL cause no state change.
REQ-021 MULT: {hi,lo} SHALL be the 64-bit two's-complement signed product. MULTU: {hi,lo} SHALL be the 64-bit unsigned product.
REQ-022 DIV: lo SHALL be the signed quotient truncated toward zero and hi the remainder, which takes the dividend's sign. DIVU: lo SHALL be the unsigned quotient and hi the unsigned remainder.
REQ-023 DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-024 DIV or DIVU with src_b=0 SHALL still run DIV_CYCLES and pulse done, but hi/lo SHALL be left unchanged.
REQ-025 Operands SHALL be captured only at the accepting edge; later changes to src_a/src_b SHALL NOT affect the result.

Reset
REQ-026 On reset assertion, asynchronously: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-027 Reset during RUN SHALL discard the pending result; hi/lo SHALL read 0 after reset, not the in-flight value.
REQ-028 While reset is held, md_op SHALL be ignored; the first request SHALL be accepted at the first rising edge after deassertion.

Verification
REQ-029 MULT with src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-030 MULTU with src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 DIV with src_a=0xFFFFFFF9 (-7), src_b=2 -> busy high exactly 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with src_a=7, src_b=0 after MTHI 0x1234/MTLO 0x5678 -> hi=0x1234, lo=0x5678 after done.
REQ-032 MULT accepted, then MTLO 0xAAAA applied at busy cycle 2 and src_a changed mid-run -> MTLO ignored; final hi/lo match the originally captured operands; a DIVU presented on the edge busy falls -> accepted with no gap.
REQ-033 DIV started, reset pulsed asynchronously (not clock-aligned) at busy cycle 4 -> busy, done, hi and lo drop to 0 immediately; no done pulse follows.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; MTHI 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy stays 0.
